// File: rtl/if_fetch.sv
// Instruction-fetch stage: direct-mapped I-cache lookup feeding IF/ID, with one
// outstanding miss serviced through a request/done handshake to the memory controller.
module if_fetch #(
  parameter int INDEX_LEN   = 7,
  parameter int ICACHE_SIZE = 128
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] pc_in,
  input  logic [5:0]  stall_in,
  input  logic        branch_or_not,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_done_i,
  input  logic [31:0] mem_data_i,
  output logic        stall_req_o,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o
);

  localparam int TAG_W = 32 - INDEX_LEN - 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DROP
  } state_t;

  state_t state_q, state_d;

  logic [ICACHE_SIZE-1:0] valid_q;
  logic [TAG_W-1:0]       tag_q  [ICACHE_SIZE];
  logic [31:0]            data_q [ICACHE_SIZE];

  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;

  logic [INDEX_LEN-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0]     rd_tag, wr_tag;
  logic                 hit;
  logic                 done;
  logic                 cache_we;
  logic                 stall_req;

  // Only the IF hold bit of the stall vector matters to this stage.
  logic unused_stall;
  assign unused_stall = ^{stall_in[5:2], stall_in[0]};

  assign rd_idx = pc_in[INDEX_LEN+1:2];
  assign rd_tag = pc_in[31:INDEX_LEN+2];
  assign wr_idx = mem_addr_q[INDEX_LEN+1:2];
  assign wr_tag = mem_addr_q[31:INDEX_LEN+2];
  assign hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);

  // The memory controller is frozen by the same rdy_in, so a done pulse
  // seen while not ready is not a real completion.
  assign done = rdy_in && mem_done_i;

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    fetch_pc_d   = fetch_pc_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    cache_we     = 1'b0;
    stall_req    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        stall_req = !hit && !branch_or_not;
        if (rdy_in) begin
          if (branch_or_not) begin
            inst_valid_d = 1'b0;
          end else if (!stall_in[1]) begin
            if (hit) begin
              inst_valid_d = 1'b1;
              inst_d       = data_q[rd_idx];
              inst_pc_d    = pc_in;
            end else begin
              inst_valid_d = 1'b0;
              mem_req_d    = 1'b1;
              mem_addr_d   = {pc_in[31:2], 2'b00};
              fetch_pc_d   = pc_in;
              state_d      = S_WAIT;
            end
          end
        end
      end

      S_WAIT: begin
        stall_req = !done;
        if (rdy_in) begin
          if (done) begin
            cache_we  = 1'b1;
            mem_req_d = 1'b0;
            state_d   = S_IDLE;
          end
          if (branch_or_not) begin
            inst_valid_d = 1'b0;
            if (!done) state_d = S_DROP;
          end else if (done && !stall_in[1]) begin
            inst_valid_d = 1'b1;
            inst_d       = mem_data_i;
            inst_pc_d    = fetch_pc_q;
          end
        end
      end

      // Transfer cannot be aborted: finish it silently, keeping the line.
      S_DROP: begin
        if (rdy_in) begin
          if (done) begin
            cache_we  = 1'b1;
            mem_req_d = 1'b0;
            state_d   = S_IDLE;
          end
          if (branch_or_not) inst_valid_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      if (cache_we) valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag/data storage is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk_in) begin
    fetch_pc_q <= fetch_pc_d;
    if (cache_we) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= mem_data_i;
    end
  end

  assign mem_req_o    = mem_req_q;
  assign mem_addr_o   = mem_addr_q;
  assign stall_req_o  = stall_req;
  assign inst_valid_o = inst_valid_q;
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: vector table of fetches plus hand-written branch, stall,
// ready and reset sequences; emitted instructions are checked against a queue.
module tb_if_fetch;

  localparam int MEM_LAT = 3;
  localparam int TMO     = 40;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] pc_in;
  logic [5:0]  stall_in;
  logic        branch_or_not;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_done_i;
  logic [31:0] mem_data_i;
  logic        stall_req_o;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;

  if_fetch #(.INDEX_LEN(7), .ICACHE_SIZE(128)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .pc_in         (pc_in),
    .stall_in      (stall_in),
    .branch_or_not (branch_or_not),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_done_i    (mem_done_i),
    .mem_data_i    (mem_data_i),
    .stall_req_o   (stall_req_o),
    .inst_valid_o  (inst_valid_o),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    bit          hit;
  } vec_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_done = 0;
  int   mcnt   = 0;
  bit   adv    = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return ({addr[31:2], 2'b00} * 32'h0001_9E37) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Memory controller: answers each request MEM_LAT request-cycles later.
  initial begin
    mem_done_i = 1'b0;
    mem_data_i = '0;
    forever begin
      @(negedge clk_in);
      mem_done_i = 1'b0;
      if (!rst_in) begin
        mcnt = 0;
      end else if (rdy_in && mem_req_o) begin
        mcnt++;
        if (mcnt == MEM_LAT) begin
          mem_done_i = 1'b1;
          mem_data_i = mem_word(mem_addr_o);
          mcnt       = 0;
          n_done++;
        end
      end
    end
  end

  // Emission monitor: an edge that advanced IF and left a valid instruction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_in);
      adv = rst_in && rdy_in && !stall_in[1];
      @(negedge clk_in);
      if (adv && inst_valid_o) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL emit_unexpected: got inst %h pc %h, want no emission", inst_o, inst_pc_o);
        end else begin
          e = sb_q.pop_front();
          chk("emit_inst", inst_o, e.inst);
          chk("emit_pc", inst_pc_o, e.pc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  task automatic fetch(input logic [31:0] pc, input bit exp_hit);
    int   cyc;
    int   d0;
    exp_t e;
    d0            = n_done;
    pc_in         = pc;
    stall_in      = 6'b0;
    branch_or_not = 1'b0;
    #1;
    chk("lookup_stall_req", 32'(stall_req_o), 32'(!exp_hit));
    e.pc   = pc;
    e.inst = mem_word(pc);
    sb_q.push_back(e);
    cyc = 0;
    while (stall_req_o === 1'b1 && cyc < TMO) begin
      @(negedge clk_in);
      #1;
      cyc++;
      if (cyc == 1) begin
        chk("miss_req", 32'(mem_req_o), 32'd1);
        chk("miss_addr", mem_addr_o, {pc[31:2], 2'b00});
      end
    end
    if (cyc >= TMO) chk("miss_timeout", 32'(stall_req_o), 32'd0);
    if (!exp_hit) chk("done_cycle_stall_clear", 32'(mem_done_i), 32'd1);
    @(negedge clk_in);
    #1;
    stall_in = 6'b000010;
    chk("mem_reads", 32'(n_done - d0), exp_hit ? 32'd0 : 32'd1);
    chk("req_clear", 32'(mem_req_o), 32'd0);
  endtask

  task automatic wait_req_low(input string name);
    int cyc;
    cyc = 0;
    while (mem_req_o === 1'b1 && cyc < TMO) begin
      @(negedge clk_in);
      #1;
      cyc++;
    end
    chk(name, 32'(mem_req_o), 32'd0);
  endtask

  initial begin
    vec_t vecs[15];
    int   d0;
    int   cyc;
    exp_t e;

    vecs[0]  = '{32'h0000_0000, 1'b0};
    vecs[1]  = '{32'h0000_0000, 1'b1};
    vecs[2]  = '{32'h0000_0004, 1'b0};
    vecs[3]  = '{32'h0000_0204, 1'b0};
    vecs[4]  = '{32'h0000_0004, 1'b0};
    vecs[5]  = '{32'h0000_0204, 1'b0};
    vecs[6]  = '{32'h0000_0204, 1'b1};
    vecs[7]  = '{32'h0000_0008, 1'b0};
    vecs[8]  = '{32'h1000_0008, 1'b0};
    vecs[9]  = '{32'h0000_0008, 1'b0};
    vecs[10] = '{32'hFFFF_FFFC, 1'b0};
    vecs[11] = '{32'hFFFF_FFFC, 1'b1};
    vecs[12] = '{32'h0000_0003, 1'b1};
    vecs[13] = '{32'h0000_0204, 1'b1};
    vecs[14] = '{32'h0000_0000, 1'b1};

    rst_in        = 1'b0;
    rdy_in        = 1'b1;
    pc_in         = '0;
    stall_in      = 6'b000010;
    branch_or_not = 1'b0;
    #1;
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_inst_valid", 32'(inst_valid_o), 32'd0);
    chk("rst_inst", inst_o, 32'd0);
    chk("rst_inst_pc", inst_pc_o, 32'd0);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);

    for (int i = 0; i < 15; i++) fetch(vecs[i].pc, vecs[i].hit);

    // IF hold after a hit: outputs frozen, no request for a would-miss pc.
    pc_in = 32'h0000_0400;
    repeat (4) begin
      @(negedge clk_in);
      #1;
      chk("hold_inst", inst_o, 32'h0000_0013);
      chk("hold_pc", inst_pc_o, 32'h0000_0000);
      chk("hold_valid", 32'(inst_valid_o), 32'd1);
      chk("hold_no_req", 32'(mem_req_o), 32'd0);
    end

    // Redirect while the miss is outstanding: transfer completes silently.
    d0       = n_done;
    pc_in    = 32'h0000_0100;
    stall_in = 6'b0;
    @(negedge clk_in);
    #1;
    branch_or_not = 1'b1;
    @(negedge clk_in);
    #1;
    branch_or_not = 1'b0;
    stall_in      = 6'b000010;
    chk("drop_inst_valid", 32'(inst_valid_o), 32'd0);
    chk("drop_stall_req", 32'(stall_req_o), 32'd0);
    chk("drop_req_held", 32'(mem_req_o), 32'd1);
    chk("drop_addr_held", mem_addr_o, 32'h0000_0100);
    wait_req_low("drop_req_release");
    chk("drop_mem_reads", 32'(n_done - d0), 32'd1);
    fetch(32'h0000_0100, 1'b1);

    // Redirect in the very cycle the word arrives.
    d0       = n_done;
    pc_in    = 32'h0000_0180;
    stall_in = 6'b0;
    @(negedge clk_in);
    #1;
    cyc = 0;
    while (mem_done_i !== 1'b1 && cyc < TMO) begin
      @(negedge clk_in);
      #1;
      cyc++;
    end
    chk("bdone_seen", 32'(mem_done_i), 32'd1);
    branch_or_not = 1'b1;
    @(negedge clk_in);
    #1;
    branch_or_not = 1'b0;
    stall_in      = 6'b000010;
    chk("bdone_inst_valid", 32'(inst_valid_o), 32'd0);
    chk("bdone_req", 32'(mem_req_o), 32'd0);
    chk("bdone_mem_reads", 32'(n_done - d0), 32'd1);
    fetch(32'h0000_0180, 1'b1);

    // IF held while the miss completes: line filled, nothing emitted.
    d0       = n_done;
    pc_in    = 32'h0000_0280;
    stall_in = 6'b0;
    @(negedge clk_in);
    #1;
    stall_in = 6'b000010;
    wait_req_low("swait_req_release");
    chk("swait_inst_valid", 32'(inst_valid_o), 32'd0);
    chk("swait_mem_reads", 32'(n_done - d0), 32'd1);
    fetch(32'h0000_0280, 1'b1);

    // Global ready low mid-miss freezes the request.
    d0       = n_done;
    pc_in    = 32'h0000_0300;
    stall_in = 6'b0;
    e.pc     = 32'h0000_0300;
    e.inst   = mem_word(32'h0000_0300);
    sb_q.push_back(e);
    @(negedge clk_in);
    #1;
    rdy_in = 1'b0;
    repeat (5) begin
      @(negedge clk_in);
      #1;
      chk("rdy_req_held", 32'(mem_req_o), 32'd1);
      chk("rdy_addr_held", mem_addr_o, 32'h0000_0300);
    end
    chk("rdy_no_read", 32'(n_done - d0), 32'd0);
    rdy_in = 1'b1;
    cyc = 0;
    while (stall_req_o === 1'b1 && cyc < TMO) begin
      @(negedge clk_in);
      #1;
      cyc++;
    end
    chk("rdy_resume", 32'(stall_req_o), 32'd0);
    @(negedge clk_in);
    #1;
    stall_in = 6'b000010;
    chk("rdy_mem_reads", 32'(n_done - d0), 32'd1);

    // Asynchronous reset in the middle of a miss.
    pc_in    = 32'h0000_0380;
    stall_in = 6'b0;
    @(negedge clk_in);
    #2;
    stall_in = 6'b000010;
    rst_in   = 1'b0;
    #1;
    chk("arst_mem_req", 32'(mem_req_o), 32'd0);
    chk("arst_mem_addr", mem_addr_o, 32'd0);
    chk("arst_inst_valid", 32'(inst_valid_o), 32'd0);
    chk("arst_inst", inst_o, 32'd0);
    chk("arst_inst_pc", inst_pc_o, 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    fetch(32'h0000_0000, 1'b0);
    fetch(32'h0000_0000, 1'b1);

    repeat (3) @(negedge clk_in);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
